mdu_unit: RTL



---
 rtl/mdu_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the EX stage; owns the architectural HI/LO.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   start, op        EX-stage MDU instruction strobe and opcode
//                    (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op)
//   rs_val, rt_val   forwarded operands, latched on the start edge
//   cancel           exception/interrupt kill of any in-flight or starting op
//   busy             operation in flight (drives ID stall)
//   hi, lo           committed HI/LO registers
module mdu_unit #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;     // bit1: divide, bit0: unsigned
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d;

    // Result datapath from the latched operands.
    logic signed [63:0] sa, sb, prod_s;
    logic [63:0]        prod_u;
    logic               div_signed, neg_a, neg_b;
    logic [31:0]        dvd, dvs, dvs_nz, uq, ur, quo, rem;

    always_comb begin
        sa     = $signed({{32{a_q[31]}}, a_q});
        sb     = $signed({{32{b_q[31]}}, b_q});
        prod_s = sa * sb;
        prod_u = {32'd0, a_q} * {32'd0, b_q};

        // Signed divide via magnitudes; this also yields 0x80000000/-1 = 0x80000000, rem 0.
        div_signed = ~op_q[0];
        neg_a  = div_signed & a_q[31];
        neg_b  = div_signed & b_q[31];
        dvd    = neg_a ? (~a_q + 32'd1) : a_q;
        dvs    = neg_b ? (~b_q + 32'd1) : b_q;
        dvs_nz = (dvs == 32'd0) ? 32'd1 : dvs;   // keeps the divider defined; result unused on /0
        uq     = dvd / dvs_nz;
        ur     = dvd % dvs_nz;
        quo    = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        rem    = neg_a ? (~ur + 32'd1) : ur;
    end

    // Next-state: cancel > running op > start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        if (cancel) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!op_q[1]) begin
                    hi_d = op_q[0] ? prod_u[63:32] : prod_s[63:32];
                    lo_d = op_q[0] ? prod_u[31:0]  : prod_s[31:0];
                end else if (b_q != 32'd0) begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
        end else if (start) begin
            case (op)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    op_d    = op[1:0];
                    a_d     = rs_val;
                    b_d     = rt_val;
                    cnt_d   = op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                end
                3'd4:    hi_d = rs_val;
                3'd5:    lo_d = rs_val;
                default: ;
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
